// File: rtl/jpeg_cone_pipe.sv
//==============================================================================
// Module   : jpeg_cone_pipe
// Purpose  : Two-stage pipelined evaluation of the 8-input JPEG timing-cone
//            function on LANES independent lanes, with valid/ready flow
//            control (full throughput, stall-in-place backpressure).
// Ports    : clk, rst           - clock (rising edge), sync active-high reset
//            in_valid/in_ready  - input handshake; in_ready is combinational
//            in_data            - lane k in bits [8k+7:8k], bit i = x[i]
//            out_valid/out_ready- output handshake
//            out_data           - bit k = cone result y of lane k
//            stats_clr          - synchronous clear of hit_cnt
//            hit_cnt            - saturating count of asserted result bits
// Options  : JPEG_CONE_STATS_EN - when defined, builds the hit counter;
//            otherwise hit_cnt is constant 0 and stats_clr is ignored.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module jpeg_cone_pipe #(
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LANES*8-1:0]   in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES-1:0]     out_data,
    input  logic                 stats_clr,
    output logic [CNT_W-1:0]     hit_cnt
);

    // Stage-1 combinational terms and stage-2 result, one bit per lane
    logic [LANES-1:0] w_r;
    logic [LANES-1:0] w_s;
    logic [LANES-1:0] w_y;

    // Stage registers
    logic [LANES-1:0] r_s1_r;
    logic [LANES-1:0] r_s1_s;
    logic [LANES-1:0] r_s1_x5;
    logic [LANES-1:0] r_s1_x6;
    logic             r_v1;
    logic [LANES-1:0] r_y;
    logic             r_v2;

    logic w_adv1;
    logic w_adv2;

    // Stage 2 may load whenever it is empty or its word leaves this cycle;
    // stage 1 may load whenever it is empty or stage 2 takes its word.
    assign w_adv2   = ~r_v2 | out_ready;
    assign w_adv1   = ~r_v1 | w_adv2;
    assign in_ready = w_adv1;

    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            logic [7:0] w_x;
            logic       w_p;
            logic       w_q;
            logic       w_t;

            assign w_x    = in_data[8*k +: 8];
            assign w_p    = w_x[0] | (~w_x[4] & w_x[7]);
            assign w_q    = ~(w_x[3] & w_x[1]);
            assign w_r[k] = ~(w_p & w_q);
            assign w_s[k] = ~(w_q & w_x[2]);

            // Second half of the cone works from the stage-1 registers
            assign w_t    = ~(r_s1_r[k] ^ r_s1_s[k]);
            assign w_y[k] = ~((w_t & r_s1_x5[k]) | (w_t & r_s1_x6[k]) |
                              (r_s1_x5[k] & r_s1_x6[k]));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_r  <= '0;
            r_s1_s  <= '0;
            r_s1_x5 <= '0;
            r_s1_x6 <= '0;
            r_v1    <= 1'b0;
            r_y     <= '0;
            r_v2    <= 1'b0;
        end else begin
            if (w_adv2) begin
                r_y  <= w_y;
                r_v2 <= r_v1;
            end
            if (w_adv1) begin
                for (int k = 0; k < LANES; k++) begin
                    r_s1_x5[k] <= in_data[8*k+5];
                    r_s1_x6[k] <= in_data[8*k+6];
                end
                r_s1_r <= w_r;
                r_s1_s <= w_s;
                r_v1   <= in_valid;
            end
        end
    end

    assign out_valid = r_v2;
    assign out_data  = r_y;

`ifdef JPEG_CONE_STATS_EN
    localparam int PC_W = $clog2(LANES + 1);

    logic [PC_W-1:0]  w_pop;
    logic [CNT_W:0]   w_sum;
    logic [CNT_W-1:0] r_hit_cnt;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < LANES; i++) begin
            w_pop = w_pop + PC_W'(r_y[i]);
        end
    end

    // One extra bit of headroom lets the saturation test see the carry
    assign w_sum = {1'b0, r_hit_cnt} + (CNT_W+1)'(w_pop);

    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            r_hit_cnt <= '0;
        end else if (r_v2 && out_ready) begin
            if (w_sum > {1'b0, {CNT_W{1'b1}}}) begin
                r_hit_cnt <= {CNT_W{1'b1}};
            end else begin
                r_hit_cnt <= w_sum[CNT_W-1:0];
            end
        end
    end

    assign hit_cnt = r_hit_cnt;
`else
    logic w_unused_stats_clr;
    assign w_unused_stats_clr = stats_clr;
    assign hit_cnt            = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_jpeg_cone_pipe.sv
//==============================================================================
// Module   : tb_jpeg_cone_pipe
// Purpose  : Self-checking bench for jpeg_cone_pipe (LANES=4, CNT_W=4).
//            Table of hand-computed cone vectors streamed at full rate, plus
//            hand-written backpressure, reset and hit-counter sequences.
//            Counter expectations follow JPEG_CONE_STATS_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_jpeg_cone_pipe;

    localparam int LANES = 4;
    localparam int CNT_W = 4;
    localparam int NVEC  = 8;

    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [LANES*8-1:0]   in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [LANES-1:0]     out_data;
    logic                 stats_clr;
    logic [CNT_W-1:0]     hit_cnt;

    jpeg_cone_pipe #(
        .LANES (LANES),
        .CNT_W (CNT_W)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .stats_clr (stats_clr),
        .hit_cnt   (hit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] din;
        logic [3:0]  exp;
    } vec_t;

    vec_t tbl [NVEC];
    int   n_chk;
    int   n_fail;
    int   exp_cnt;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called after the cycle's inputs are driven: checks registered outputs,
    // optionally in_ready, then updates the counter expectation.
    task automatic cyc(input logic ev, input logic [3:0] ed, input logic erdy, input logic do_rdy);
        cmp("out_valid", {31'd0, out_valid}, {31'd0, ev});
        if (ev) cmp("out_data", {28'd0, out_data}, {28'd0, ed});
        cmp("hit_cnt", {28'd0, hit_cnt}, exp_cnt);
        #1;
        if (do_rdy) cmp("in_ready", {31'd0, in_ready}, {31'd0, erdy});
`ifdef JPEG_CONE_STATS_EN
        if (rst || stats_clr) begin
            exp_cnt = 0;
        end else if (ev && out_ready) begin
            exp_cnt = exp_cnt + $countones(ed);
            if (exp_cnt > 15) exp_cnt = 15;
        end
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // word = lane3 lane2 lane1 lane0; expected nibble = y3 y2 y1 y0
        tbl[0] = '{32'h2561FF00, 4'b0001};
        tbl[1] = '{32'h01010101, 4'b1111};
        tbl[2] = '{32'h05050505, 4'b1111};
        tbl[3] = '{32'h80900A60, 4'b1110};
        tbl[4] = '{32'h20042464, 4'b0110};
        tbl[5] = '{32'h0B6B0747, 4'b1010};
        tbl[6] = '{32'h65454100, 4'b0011};
        tbl[7] = '{32'hFFFFFFFF, 4'b0000};

        n_chk     = 0;
        n_fail    = 0;
        exp_cnt   = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        stats_clr = 1'b0;
        repeat (3) tick();

        // Reset state
        rst = 1'b0;
        cmp("rst_out_valid", {31'd0, out_valid}, 32'd0);
        cmp("rst_out_data", {28'd0, out_data}, 32'd0);
        cmp("rst_hit_cnt", {28'd0, hit_cnt}, 32'd0);

        // Full-rate stream of the vector table
        for (int c = 0; c < NVEC + 2; c++) begin
            in_valid  = (c < NVEC);
            in_data   = (c < NVEC) ? tbl[c].din : '0;
            out_ready = 1'b1;
            cyc(c >= 2, (c >= 2) ? tbl[(c >= 2) ? c - 2 : 0].exp : 4'd0, 1'b1, 1'b1);
            tick();
        end
        in_valid = 1'b0;
        cyc(1'b0, 4'd0, 1'b1, 1'b1);
        tick();

        // Backpressure: 5 stalled cycles, two words buffered, then drain
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = tbl[3].din;
        cyc(1'b0, 4'd0, 1'b1, 1'b1);
        tick();
        in_data = tbl[4].din;
        cyc(1'b0, 4'd0, 1'b1, 1'b1);
        tick();
        in_data = tbl[5].din;
        for (int c = 2; c < 5; c++) begin
            cyc(1'b1, tbl[3].exp, 1'b0, 1'b1);
            tick();
        end
        out_ready = 1'b1;
        cyc(1'b1, tbl[3].exp, 1'b1, 1'b1);
        tick();
        in_valid = 1'b0;
        cyc(1'b1, tbl[4].exp, 1'b1, 1'b1);
        tick();
        cyc(1'b1, tbl[5].exp, 1'b1, 1'b1);
        tick();
        cyc(1'b0, 4'd0, 1'b1, 1'b1);
        tick();

        // Reset with both stages full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = tbl[3].din;
        cyc(1'b0, 4'd0, 1'b1, 1'b1);
        tick();
        in_data = tbl[4].din;
        cyc(1'b0, 4'd0, 1'b1, 1'b1);
        tick();
        rst       = 1'b1;
        out_ready = 1'b1;
        cyc(1'b1, tbl[3].exp, 1'b0, 1'b0);
        tick();
        rst     = 1'b0;
        in_data = tbl[2].din;
        cmp("post_rst_out_data", {28'd0, out_data}, 32'd0);
        cyc(1'b0, 4'd0, 1'b1, 1'b1);
        tick();
        in_valid = 1'b0;
        cyc(1'b0, 4'd0, 1'b1, 1'b1);
        tick();
        cyc(1'b1, tbl[2].exp, 1'b1, 1'b1);
        tick();
        cyc(1'b0, 4'd0, 1'b1, 1'b1);
        tick();

        // Counter: clear, saturate with 1111 words, then clear during a transfer
        stats_clr = 1'b1;
        cyc(1'b0, 4'd0, 1'b1, 1'b1);
        tick();
        stats_clr = 1'b0;
        for (int c = 0; c < 9; c++) begin
            in_valid  = (c < 6);
            in_data   = tbl[1].din;
            stats_clr = (c == 7);
            cyc(c >= 2 && c < 8, tbl[1].exp, 1'b1, 1'b1);
            tick();
        end
        stats_clr = 1'b0;
        cyc(1'b0, 4'd0, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
